// File: rtl/mmu_tile_loader.sv
// Operand/result sequencer around the matrix-multiply unit: assembles the A, B and C banks
// from a serial element stream, runs the MMU and streams the result back out row-major.
module mmu_tile_loader #(
    parameter int NUM_ROWS_A = 1,
    parameter int NUM_COLS_A = 1,
    parameter int NUM_COLS_B = 1,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [DATA_WIDTH-1:0]                                   in_data,
    input  logic                                                    use_accum,
    output logic                                                    mmu_enable,
    output logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0]   mmu_mat_in1,
    output logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0]   mmu_mat_in2,
    output logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0]   mmu_mat_in_accum,
    input  logic                                                    mmu_data_ready,
    input  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0]   mmu_mat_out,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic [DATA_WIDTH-1:0]                                   out_data,
    output logic                                                    out_last,
    output logic                                                    busy,
    output logic                                                    done,
    output logic                                                    timeout_err
);

    localparam int A_N    = NUM_ROWS_A * NUM_COLS_A;
    localparam int B_N    = NUM_COLS_A * NUM_COLS_B;
    localparam int R_N    = NUM_ROWS_A * NUM_COLS_B;
    localparam int MAX_AB = (A_N > B_N) ? A_N : B_N;
    localparam int MAX_N  = (MAX_AB > R_N) ? MAX_AB : R_N;
    localparam int IDX_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    if (FIXED_PNT >= DATA_WIDTH) begin : g_bad_fixed_pnt
        $error("FIXED_PNT must leave at least one integer bit");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_LOAD_C  = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    state_t                          state_r, state_s;
    logic [IDX_W-1:0]                idx_r;
    logic [TMO_W-1:0]                tmo_r;
    logic                            use_accum_r;
    logic [A_N-1:0][DATA_WIDTH-1:0]  a_bank_r;
    logic [B_N-1:0][DATA_WIDTH-1:0]  b_bank_r;
    logic [R_N-1:0][DATA_WIDTH-1:0]  c_bank_r;
    logic [R_N-1:0][DATA_WIDTH-1:0]  res_r;
    logic [R_N-1:0][DATA_WIDTH-1:0]  mat_out_s;
    logic [DATA_WIDTH-1:0]           out_data_r;
    logic                            out_last_r;
    logic in_ready_r, mmu_enable_r, out_valid_r, busy_r, done_r, timeout_err_r;
    logic in_ready_s, mmu_enable_s, out_valid_s, busy_s, done_s, timeout_err_s;
    logic in_acc_s, hs_s, a_last_s, b_last_s, c_last_s, r_last_s, tmo_hit_s;

    // Handshake qualifiers use the registered ready/valid so they match what the peers see.
    assign in_acc_s  = in_valid && in_ready_r;
    assign hs_s      = out_valid_r && out_ready;
    assign a_last_s  = (idx_r == IDX_W'(A_N - 1));
    assign b_last_s  = (idx_r == IDX_W'(B_N - 1));
    assign c_last_s  = (idx_r == IDX_W'(R_N - 1));
    assign r_last_s  = (idx_r == IDX_W'(R_N - 1));
    assign tmo_hit_s = (tmo_r == TMO_W'(TIMEOUT - 1));
    assign mat_out_s = mmu_mat_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_acc_s) state_s = (A_N == 1) ? ST_LOAD_B : ST_LOAD_A;
                else          state_s = ST_IDLE;
            end
            ST_LOAD_A: begin
                if (in_acc_s && a_last_s) state_s = ST_LOAD_B;
                else                      state_s = ST_LOAD_A;
            end
            ST_LOAD_B: begin
                if (in_acc_s && b_last_s) state_s = use_accum_r ? ST_LOAD_C : ST_COMPUTE;
                else                      state_s = ST_LOAD_B;
            end
            ST_LOAD_C: begin
                if (in_acc_s && c_last_s) state_s = ST_COMPUTE;
                else                      state_s = ST_LOAD_C;
            end
            ST_COMPUTE: begin
                if (mmu_data_ready) state_s = ST_CAPTURE;
                else if (tmo_hit_s) state_s = ST_IDLE;
                else                state_s = ST_COMPUTE;
            end
            ST_CAPTURE: state_s = ST_DRAIN;
            ST_DRAIN: begin
                if (hs_s && r_last_s) state_s = ST_IDLE;
                else                  state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the control outputs leave a register.
    always_comb begin
        in_ready_s    = (state_s == ST_IDLE) || (state_s == ST_LOAD_A) ||
                        (state_s == ST_LOAD_B) || (state_s == ST_LOAD_C);
        mmu_enable_s  = (state_s == ST_COMPUTE);
        out_valid_s   = (state_s == ST_DRAIN);
        busy_s        = (state_s != ST_IDLE);
        done_s        = (state_r == ST_DRAIN) && hs_s && r_last_s;
        timeout_err_s = (state_r == ST_COMPUTE) && !mmu_data_ready && tmo_hit_s;
    end

    // Control output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r    <= 1'b0;
            mmu_enable_r  <= 1'b0;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            in_ready_r    <= in_ready_s;
            mmu_enable_r  <= mmu_enable_s;
            out_valid_r   <= out_valid_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    // Bank loading, timeout counting, result capture and drain sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= {IDX_W{1'b0}};
            tmo_r       <= {TMO_W{1'b0}};
            use_accum_r <= 1'b0;
            a_bank_r    <= {(A_N*DATA_WIDTH){1'b0}};
            b_bank_r    <= {(B_N*DATA_WIDTH){1'b0}};
            c_bank_r    <= {(R_N*DATA_WIDTH){1'b0}};
            res_r       <= {(R_N*DATA_WIDTH){1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_acc_s) begin
                        a_bank_r[0] <= in_data;
                        use_accum_r <= use_accum;
                        idx_r       <= (A_N == 1) ? {IDX_W{1'b0}} : IDX_W'(1);
                    end
                end
                ST_LOAD_A: begin
                    if (in_acc_s) begin
                        for (int k = 0; k < A_N; k++) begin
                            if (idx_r == IDX_W'(k)) a_bank_r[k] <= in_data;
                        end
                        idx_r <= a_last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
                    end
                end
                ST_LOAD_B: begin
                    if (in_acc_s) begin
                        for (int k = 0; k < B_N; k++) begin
                            if (idx_r == IDX_W'(k)) b_bank_r[k] <= in_data;
                        end
                        if (b_last_s) begin
                            idx_r <= {IDX_W{1'b0}};
                            tmo_r <= {TMO_W{1'b0}};
                            if (!use_accum_r) c_bank_r <= {(R_N*DATA_WIDTH){1'b0}};
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_LOAD_C: begin
                    if (in_acc_s) begin
                        for (int k = 0; k < R_N; k++) begin
                            if (idx_r == IDX_W'(k)) c_bank_r[k] <= in_data;
                        end
                        if (c_last_s) begin
                            idx_r <= {IDX_W{1'b0}};
                            tmo_r <= {TMO_W{1'b0}};
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_COMPUTE: tmo_r <= tmo_r + TMO_W'(1);
                ST_CAPTURE: begin
                    // The MMU result register has settled one edge after its ready pulse.
                    res_r      <= mmu_mat_out;
                    out_data_r <= mat_out_s[0];
                    out_last_r <= (R_N == 1);
                    idx_r      <= {IDX_W{1'b0}};
                end
                ST_DRAIN: begin
                    if (hs_s) begin
                        if (r_last_s) begin
                            idx_r      <= {IDX_W{1'b0}};
                            out_data_r <= {DATA_WIDTH{1'b0}};
                            out_last_r <= 1'b0;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                            for (int k = 0; k < R_N; k++) begin
                                if (idx_r + IDX_W'(1) == IDX_W'(k)) out_data_r <= res_r[k];
                            end
                            out_last_r <= (idx_r + IDX_W'(1) == IDX_W'(R_N - 1));
                        end
                    end
                end
                default: idx_r <= {IDX_W{1'b0}};
            endcase
        end
    end

    assign in_ready         = in_ready_r;
    assign mmu_enable       = mmu_enable_r;
    assign mmu_mat_in1      = a_bank_r;
    assign mmu_mat_in2      = b_bank_r;
    assign mmu_mat_in_accum = c_bank_r;
    assign out_valid        = out_valid_r;
    assign out_data         = out_data_r;
    assign out_last         = out_last_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign timeout_err      = timeout_err_r;

endmodule

// File: tb/tb_mmu_tile_loader.sv
// Self-checking bench for mmu_tile_loader (2x2x2, Q8.8) with a behavioural 2-cycle MMU
// and a scoreboard queue of expected result elements.
module tb_mmu_tile_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   in_valid, in_ready, use_accum, mmu_enable, mmu_data_ready;
    logic [15:0]            in_data, out_data;
    logic [1:0][1:0][15:0]  mmu_mat_in1, mmu_mat_in2, mmu_mat_in_accum, mmu_mat_out;
    logic                   out_valid, out_ready, out_last, busy, done, timeout_err;
    logic                   mmu_respond;
    logic [1:0]             mcnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    mmu_tile_loader #(
        .NUM_ROWS_A(2), .NUM_COLS_A(2), .NUM_COLS_B(2),
        .DATA_WIDTH(16), .FIXED_PNT(8), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .use_accum(use_accum),
        .mmu_enable(mmu_enable), .mmu_mat_in1(mmu_mat_in1), .mmu_mat_in2(mmu_mat_in2),
        .mmu_mat_in_accum(mmu_mat_in_accum), .mmu_data_ready(mmu_data_ready),
        .mmu_mat_out(mmu_mat_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    // Behavioural MMU: ready two cycles after enable rises, result registered on the ready edge.
    function automatic logic [15:0] mmu_elem(input int i, input int j);
        int acc;
        acc = int'($signed(mmu_mat_in_accum[i][j]));
        for (int k = 0; k < 2; k++)
            acc += (int'($signed(mmu_mat_in1[i][k])) * int'($signed(mmu_mat_in2[k][j]))) >>> 8;
        return acc[15:0];
    endfunction

    assign mmu_data_ready = mmu_respond && mmu_enable && (mcnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt        <= 2'd0;
            mmu_mat_out <= '0;
        end else begin
            if (!mmu_enable)        mcnt <= 2'd0;
            else if (mcnt != 2'd3)  mcnt <= mcnt + 2'd1;
            if (mmu_data_ready)
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        mmu_mat_out[i][j] <= mmu_elem(i, j);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a[4];
        logic [15:0] b[4];
        logic [15:0] c[4];
        logic        use_acc;
        logic [15:0] exp[4];
        int          stall;
        int          gap;
    } vec_t;

    vec_t vecs[5];

    task automatic load_job(input vec_t v, input bit push);
        logic [15:0] el[12];
        int n;
        n = v.use_acc ? 12 : 8;
        for (int k = 0; k < 4; k++) begin
            el[k] = v.a[k]; el[k+4] = v.b[k]; el[k+8] = v.c[k];
        end
        if (push) for (int k = 0; k < 4; k++) exp_q.push_back(v.exp[k]);
        use_accum = v.use_acc;
        for (int k = 0; k < n; k++) begin
            if (v.gap != 0 && k > 0) begin
                @(negedge clk); in_valid = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            chk("in_ready_load", in_ready, 1'b1);
            in_valid = 1'b1; in_data = el[k];
            @(posedge clk); #1;
            chk("enable_after_elem", mmu_enable, (k == n-1));
        end
        in_valid = 1'b0;
        chk("bank_a", mmu_mat_in1, {v.a[3], v.a[2], v.a[1], v.a[0]});
        chk("bank_b", mmu_mat_in2, {v.b[3], v.b[2], v.b[1], v.b[0]});
        chk("bank_c", mmu_mat_in_accum, v.use_acc ? {v.c[3], v.c[2], v.c[1], v.c[0]} : 64'd0);
    endtask

    // Starts in the first COMPUTE cycle; stops after `target` output handshakes.
    task automatic collect(input int stall_mode, input int target);
        int hs = 0, cyc = 0, en_cnt = 0, first_valid = -1, lasts = 0;
        logic stalled = 1'b0;
        logic [15:0] held = 16'h0, e;
        while (hs < target && cyc < 100) begin
            @(negedge clk);
            if (mmu_enable) en_cnt++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                chk("stall_hold_data", out_data, held);
                chk("stall_hold_valid", out_valid, 1'b1);
            end
            out_ready = (stall_mode != 0) ? (cyc % 3 == 2) : 1'b1;
            stalled = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
                chk("out_last", out_last, (hs == 3));
                if (out_last) lasts++;
                hs++;
            end
            cyc++;
        end
        if (hs < target) chk("drain_budget", hs, target);
        chk("valid_at_E_plus_4", first_valid, 4);
        chk("enable_cycles", en_cnt, 3);
        @(posedge clk);
        if (target == 4) begin
            @(negedge clk);
            out_ready = 1'b0;
            chk("done_pulse", done, 1'b1);
            chk("busy_after_done", busy, 1'b0);
            chk("valid_after_done", out_valid, 1'b0);
            chk("last_count", lasts, 1);
            @(negedge clk);
            chk("done_one_cycle", done, 1'b0);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_data = 16'h0; use_accum = 1'b0; out_ready = 1'b0; mmu_respond = 1'b1;

        vecs[0] = '{a: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}, b: '{16'h0100, 16'h0000, 16'h0000, 16'h0100},
                    c: '{16'h0, 16'h0, 16'h0, 16'h0}, use_acc: 1'b0,
                    exp: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}, stall: 0, gap: 0};
        vecs[1] = '{a: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}, b: '{16'h0100, 16'h0000, 16'h0000, 16'h0100},
                    c: '{16'h0080, 16'h0080, 16'h0080, 16'h0080}, use_acc: 1'b1,
                    exp: '{16'h0180, 16'h0280, 16'h0380, 16'h0480}, stall: 0, gap: 0};
        vecs[2] = '{a: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}, b: '{16'h0100, 16'h0000, 16'h0000, 16'h0100},
                    c: '{16'h0, 16'h0, 16'h0, 16'h0}, use_acc: 1'b0,
                    exp: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}, stall: 1, gap: 0};
        vecs[3] = '{a: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}, b: '{16'h0100, 16'h0000, 16'h0000, 16'h0100},
                    c: '{16'h0080, 16'h0080, 16'h0080, 16'h0080}, use_acc: 1'b1,
                    exp: '{16'h0180, 16'h0280, 16'h0380, 16'h0480}, stall: 0, gap: 1};
        // A times 2I, no accumulator, with input gaps: 1,2,3,4 -> 2,4,6,8.
        vecs[4] = '{a: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}, b: '{16'h0200, 16'h0000, 16'h0000, 16'h0200},
                    c: '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, use_acc: 1'b0,
                    exp: '{16'h0200, 16'h0400, 16'h0600, 16'h0800}, stall: 1, gap: 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_enable", mmu_enable, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flags", {done, timeout_err, out_last}, 3'b000);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_banks", {mmu_mat_in1, mmu_mat_in2}, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 5; i++) begin
            load_job(vecs[i], 1'b1);
            collect(vecs[i].stall, 4);
        end

        // Timeout: MMU never answers.
        begin
            int en_cnt = 0, cyc = 0, ov = 0;
            bit seen = 1'b0;
            mmu_respond = 1'b0;
            load_job(vecs[0], 1'b0);
            while (!seen && cyc < 40) begin
                @(negedge clk);
                if (mmu_enable) en_cnt++;
                if (out_valid) ov++;
                if (timeout_err) begin
                    seen = 1'b1;
                    chk("timeout_busy", busy, 1'b0);
                    chk("timeout_enable_cycles", en_cnt, 16);
                end
                cyc++;
            end
            chk("timeout_seen", seen, 1'b1);
            chk("timeout_no_output", ov, 0);
            @(negedge clk);
            chk("timeout_one_cycle", timeout_err, 1'b0);
            chk("timeout_idle", in_ready, 1'b1);
            mmu_respond = 1'b1;
        end

        // Reset after the second output handshake, then a clean job.
        load_job(vecs[1], 1'b1);
        collect(0, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {out_valid, mmu_enable, busy, done, timeout_err, in_ready, out_last}, 7'd0);
        chk("midrst_out_data", out_data, 16'h0);
        chk("midrst_banks", {mmu_mat_in1, mmu_mat_in2, mmu_mat_in_accum}, 192'd0);
        exp_q.delete();
        out_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", in_ready, 1'b1);
        load_job(vecs[0], 1'b1);
        collect(0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
